// File: rtl/pu_fifo_ctrl_if.sv
// Bus between pu_fifo_ctrl and the shared pu_fifo instance.
// The controller drives strobes and write data; the FIFO returns read data.
interface pu_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic [ATTR_WIDTH-1:0] fifo_attr_in;
  logic                  fifo_wr;
  logic                  fifo_oe;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic [ATTR_WIDTH-1:0] fifo_attr_out;

  modport master (
    output fifo_data_in,
    output fifo_attr_in,
    output fifo_wr,
    output fifo_oe,
    input  fifo_data_out,
    input  fifo_attr_out
  );

  modport slave (
    input  fifo_data_in,
    input  fifo_attr_in,
    input  fifo_wr,
    input  fifo_oe,
    output fifo_data_out,
    output fifo_attr_out
  );
endinterface

// File: rtl/pu_fifo_ctrl.sv
// Shares one pu_fifo between N_REQ round-robin producers and one consumer,
// tracking occupancy and providing a flush that drains without delivering data.
module pu_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int FIFO_SIZE  = 3,
  parameter int N_REQ      = 2,
  localparam int CNT_W     = $clog2(FIFO_SIZE + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [N_REQ*ATTR_WIDTH-1:0]   req_attr,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [ATTR_WIDTH-1:0]         rd_attr,
  output logic                          rd_err,
  input  logic                          flush,
  output logic                          busy_flush,
  output logic [CNT_W-1:0]              count,
  output logic                          full,
  output logic                          empty,
  pu_fifo_ctrl_if.master                fifo
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_SIZE);
  localparam logic [PTR_W:0]   N_REQ_W  = (PTR_W + 1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(N_REQ - 1);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]            state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]      cnt_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ATTR_WIDTH-1:0] wattr_q;
  logic                  oe_q;
  logic                  deliver_q;
  logic                  rd_valid_q;
  logic                  rd_err_q;

  logic                  wr_acc;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W:0]        cand;
  logic                  accept_ok;
  logic                  rd_acc;
  logic                  drain;
  logic                  pop;
  logic [DATA_WIDTH-1:0] win_data;
  logic [ATTR_WIDTH-1:0] win_attr;
  logic [PTR_W-1:0]      next_ptr;

  // New accepts only in RUN, never in a flush-request cycle, and never at full
  // (a pop accepted in the same cycle does not free a slot until next cycle).
  assign accept_ok = !rst && (state == RUN) && !flush;

  always_comb begin
    req_ready = '0;
    wr_acc    = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (accept_ok && (cnt_q != FULL_CNT)) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
        if (cand >= N_REQ_W) cand = cand - N_REQ_W;
        if (!wr_acc && req_valid[cand[PTR_W-1:0]]) begin
          wr_acc  = 1'b1;
          win_idx = cand[PTR_W-1:0];
        end
      end
    end
    if (wr_acc) req_ready[win_idx] = 1'b1;
  end

  assign win_data = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
  assign win_attr = req_attr[win_idx*ATTR_WIDTH +: ATTR_WIDTH];
  assign next_ptr = (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;

  assign rd_acc = rd_req && accept_ok && (cnt_q != '0);
  assign drain  = (state == FLUSH) && (cnt_q != '0);
  assign pop    = rd_acc || drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      rr_ptr     <= '0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      wattr_q    <= '0;
      oe_q       <= 1'b0;
      deliver_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      case (state)
        RUN:     if (flush) state <= FLUSH;
        // Wait for the last drain strobe to retire before leaving FLUSH.
        FLUSH:   if ((cnt_q == '0) && !oe_q) state <= RUN;
        default: state <= RUN;
      endcase

      if (wr_acc) rr_ptr <= next_ptr;

      wr_q    <= wr_acc;
      wdata_q <= wr_acc ? win_data : '0;
      wattr_q <= wr_acc ? win_attr : '0;

      // deliver_q separates consumer pops from drain pops one cycle later.
      oe_q       <= pop;
      deliver_q  <= rd_acc;
      rd_valid_q <= oe_q && deliver_q;
      rd_err_q   <= rd_req && !rd_acc;

      case ({wr_acc, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign count      = cnt_q;
  assign full       = (cnt_q == FULL_CNT);
  assign empty      = (cnt_q == '0);
  assign busy_flush = (state == FLUSH);
  assign rd_valid   = rd_valid_q;
  assign rd_err     = rd_err_q;
  assign rd_data    = rd_valid_q ? fifo.fifo_data_out : '0;
  assign rd_attr    = rd_valid_q ? fifo.fifo_attr_out : '0;

  assign fifo.fifo_wr      = wr_q;
  assign fifo.fifo_oe      = oe_q;
  assign fifo.fifo_data_in = wdata_q;
  assign fifo.fifo_attr_in = wattr_q;

  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    cnt_q <= FULL_CNT);
  a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));
  a_no_write_at_full : assert property (@(posedge clk) disable iff (rst)
    full |-> (req_ready == '0));

endmodule

// File: tb/tb_pu_fifo_ctrl.sv
// Directed bench for pu_fifo_ctrl with a behavioural pu_fifo stub on the bus.
module tb_pu_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [NR-1:0] req_ready;
  logic          rd_req = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_attr;
  logic          rd_err;
  logic          flush = 1'b0;
  logic          busy_flush;
  logic [1:0]    count;
  logic          full, empty;

  int n_chk = 0;
  int n_err = 0;

  pu_fifo_ctrl_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW)) fif ();

  pu_fifo_ctrl #(
    .DATA_WIDTH(DW), .ATTR_WIDTH(AW), .FIFO_SIZE(3), .N_REQ(NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   ({d1, d0}),
    .req_attr   ({a1, a0}),
    .req_ready  (req_ready),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_attr    (rd_attr),
    .rd_err     (rd_err),
    .flush      (flush),
    .busy_flush (busy_flush),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .fifo       (fif)
  );

  always #5 clk = ~clk;

  // pu_fifo stub: output is valid the cycle after signal_oe
  logic [DW+AW-1:0] q[$];
  logic [DW+AW-1:0] popped;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      fif.fifo_data_out <= '0;
      fif.fifo_attr_out <= '0;
    end else begin
      if (fif.fifo_wr) q.push_back({fif.fifo_attr_in, fif.fifo_data_in});
      if (fif.fifo_oe && q.size() > 0) begin
        popped = q.pop_front();
        fif.fifo_data_out <= popped[DW-1:0];
        fif.fifo_attr_out <= popped[DW+AW-1:DW];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; rd_req = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  int oe_cnt, rv_cnt, busy_cnt;

  initial begin
    // 1: single write then single read
    do_reset();
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_count", count, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_wr", fif.fifo_wr, 0);
    check_eq("rst_oe", fif.fifo_oe, 0);
    check_eq("rst_rdvalid", rd_valid, 0);
    check_eq("rst_busy", busy_flush, 0);
    req_valid = 2'b01; d0 = 11; a0 = 3; #1;
    check_eq("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check_eq("t1_wr", fif.fifo_wr, 1);
    check_eq("t1_wdata", fif.fifo_data_in, 11);
    check_eq("t1_wattr", fif.fifo_attr_in, 3);
    check_eq("t1_count1", count, 1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check_eq("t1_oe", fif.fifo_oe, 1);
    check_eq("t1_count0", count, 0);
    check_eq("t1_wr_idle_data", fif.fifo_data_in, 0);
    tick();
    check_eq("t1_rdvalid", rd_valid, 1);
    check_eq("t1_rdata", rd_data, 11);
    check_eq("t1_rattr", rd_attr, 3);
    tick();
    check_eq("t1_rdvalid_off", rd_valid, 0);

    // 2: round-robin fill to full
    do_reset();
    d0 = 21; a0 = 1; d1 = 22; a1 = 2;
    req_valid = 2'b11; #1;
    check_eq("t2_g0", req_ready, 2'b01);
    tick();
    check_eq("t2_g1", req_ready, 2'b10);
    check_eq("t2_wd0", fif.fifo_data_in, 21);
    tick();
    check_eq("t2_g2", req_ready, 2'b01);
    check_eq("t2_wd1", fif.fifo_data_in, 22);
    tick();
    check_eq("t2_g3", req_ready, 2'b00);
    check_eq("t2_full", full, 1);
    check_eq("t2_count", count, 3);

    // 3: full plus pop in the same cycle: no grant until the next cycle
    rd_req = 1'b1; #1;
    check_eq("t3_nogrant", req_ready, 2'b00);
    tick();
    rd_req = 1'b0;
    check_eq("t3_count2", count, 2);
    check_eq("t3_oe", fif.fifo_oe, 1);
    check_eq("t3_notfull", full, 0);
    check_eq("t3_grant", req_ready, 2'b10);
    tick();
    req_valid = '0;
    check_eq("t3_count3", count, 3);
    check_eq("t3_wd", fif.fifo_data_in, 22);
    check_eq("t3_rdvalid", rd_valid, 1);
    check_eq("t3_rdata", rd_data, 21);
    check_eq("t3_rattr", rd_attr, 1);

    // 4: read while empty
    do_reset();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check_eq("t4_err", rd_err, 1);
    check_eq("t4_oe", fif.fifo_oe, 0);
    check_eq("t4_count", count, 0);
    tick();
    check_eq("t4_err_pulse", rd_err, 0);

    // 5: three writes then flush
    do_reset();
    req_valid = 2'b01; d0 = 13; a0 = 5;
    tick(); d0 = 14;
    tick(); d0 = 15;
    tick();
    req_valid = '0;
    check_eq("t5_count3", count, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("t5_busy", busy_flush, 1);
    req_valid = 2'b01; rd_req = 1'b1; #1;
    check_eq("t5_noready", req_ready, 2'b00);
    oe_cnt = 0; rv_cnt = 0; busy_cnt = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        check_eq("t5_rderr", rd_err, 1);
        req_valid = '0; rd_req = 1'b0;
      end
      if (fif.fifo_oe) oe_cnt++;
      if (rd_valid) rv_cnt++;
      if (busy_flush) busy_cnt++;
    end
    check_eq("t5_oe_cnt", oe_cnt, 3);
    check_eq("t5_rv_cnt", rv_cnt, 0);
    check_eq("t5_busy_cnt", busy_cnt, 5);
    check_eq("t5_empty", empty, 1);
    check_eq("t5_run", busy_flush, 0);
    req_valid = 2'b01; #1;
    check_eq("t5_resume", req_ready, 2'b01);
    req_valid = '0;

    // 6: reset in the middle of a write burst
    do_reset();
    d0 = 31; d1 = 32;
    req_valid = 2'b11;
    tick(); tick();
    check_eq("t6_count2", count, 2);
    rst = 1'b1; #1;
    check_eq("t6_ready_in_rst", req_ready, 0);
    tick();
    check_eq("t6_count", count, 0);
    check_eq("t6_empty", empty, 1);
    check_eq("t6_wr", fif.fifo_wr, 0);
    check_eq("t6_wdata", fif.fifo_data_in, 0);
    check_eq("t6_oe", fif.fifo_oe, 0);
    check_eq("t6_rdvalid", rd_valid, 0);
    check_eq("t6_busy", busy_flush, 0);
    rst = 1'b0; #1;
    check_eq("t6_grant_p0", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check_eq("t6_wdata_p0", fif.fifo_data_in, 31);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule
